// File: rtl/dma_pkg.sv
// Shared DMA-engine types: arbiter state encodings, default sizing, bus slice widths.
// Pure declarations; no latency or flow-control behaviour of its own.
package dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } arb_state_e;

  localparam int N_DEF       = 5;
  localparam int TIMEOUT_DEF = 255;
  localparam int SEL_W       = 4;
  localparam int DAT_W       = 32;

  function automatic int oh2idx(input logic [31:0] oh);
    oh2idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) oh2idx = i;
    end
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, searches upward from last+1 modulo N.
// Zero latency; no flow control, winner is valid whenever any request bit is set.
module rr_pick #(
  parameter int N  = 5,
  parameter int LW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((32'(last_i) + 32'(k)) % 32'(N));
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    vld_o = |req_i;
  end

endmodule

// File: rtl/wb_arb.sv
// wb_arb: round-robin Wishbone master-port arbiter; grant 1 cycle after request, responses combinational.
// Owner keeps the bus until it drops cyc; others wait. WB_ARB_TIMEOUT_EN adds a no-response abort.
module wb_arb
  import dma_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [N-1:0]       m_cyc_i,
  input  logic [N-1:0]       m_stb_i,
  input  logic [N-1:0]       m_we_i,
  input  logic [N-1:0]       m_cab_i,
  input  logic [SEL_W*N-1:0] m_sel_i,
  input  logic [DAT_W*N-1:0] m_adr_i,
  input  logic [DAT_W*N-1:0] m_dat_i,
  input  logic [DAT_W*N-1:0] m_dat64_i,
  output logic [DAT_W-1:0]   m_dat_o,
  output logic [DAT_W-1:0]   m_dat64_o,
  output logic [N-1:0]       m_ack_o,
  output logic [N-1:0]       m_err_o,
  output logic [N-1:0]       m_rty_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic               wb_cab_o,
  output logic [SEL_W-1:0]   wb_sel_o,
  output logic [DAT_W-1:0]   wb_adr_o,
  output logic [DAT_W-1:0]   wb_dat_o,
  output logic [DAT_W-1:0]   wb_dat64_o,
  input  logic [DAT_W-1:0]   wb_dat_i,
  input  logic [DAT_W-1:0]   wb_dat64_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic               wb_rty_i,
  output logic [N-1:0]       gnt_o,
  output logic [1:0]         arb_state
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  // The abort counter is 8 bits wide, so TIMEOUT must fit in it.
  if (N < 2 || N > 32 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("wb_arb: unsupported N or TIMEOUT");
  end

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d;

  logic [N-1:0]  pick_oh;
  logic          pick_vld;

  logic             own_cyc, own_stb, own_we, own_cab;
  logic [SEL_W-1:0] own_sel;
  logic [DAT_W-1:0] own_adr, own_dat, own_dat64;
  logic             bus_on, qual_on, resp;
  logic             tmo_hit;

  rr_pick #(
    .N  (N),
    .LW (LW)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_oh),
    .vld_o  (pick_vld)
  );

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_cab   = 1'b0;
    own_sel   = '0;
    own_adr   = '0;
    own_dat   = '0;
    own_dat64 = '0;
    for (int i = 0; i < N; i++) begin
      own_cyc   |= m_cyc_i[i] & gnt_q[i];
      own_stb   |= m_stb_i[i] & gnt_q[i];
      own_we    |= m_we_i[i]  & gnt_q[i];
      own_cab   |= m_cab_i[i] & gnt_q[i];
      own_sel   |= m_sel_i[i*SEL_W +: SEL_W]   & {SEL_W{gnt_q[i]}};
      own_adr   |= m_adr_i[i*DAT_W +: DAT_W]   & {DAT_W{gnt_q[i]}};
      own_dat   |= m_dat_i[i*DAT_W +: DAT_W]   & {DAT_W{gnt_q[i]}};
      own_dat64 |= m_dat64_i[i*DAT_W +: DAT_W] & {DAT_W{gnt_q[i]}};
    end
  end

  assign resp = wb_ack_i | wb_err_i | wb_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign tmo_hit = !wb_rst_i && (state_q == S_BUSY) && own_cyc && (tmo_q == 8'(TIMEOUT));

  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q || resp) begin
      tmo_d = '0;
    end else if (state_q == S_BUSY && wb_stb_o) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Release by the owner always takes priority; new requests wait for the next idle cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_oh;
          last_d  = LW'(oh2idx(32'(pick_oh)));
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!own_cyc) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (!own_cyc) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus_on     = !wb_rst_i && (state_q == S_BUSY);
    qual_on    = !wb_rst_i && (|gnt_q);
    wb_cyc_o   = bus_on & own_cyc;
    wb_stb_o   = bus_on & own_stb;
    wb_cab_o   = bus_on & own_cab;
    wb_we_o    = qual_on & own_we;
    wb_sel_o   = qual_on ? own_sel   : '0;
    wb_adr_o   = qual_on ? own_adr   : '0;
    wb_dat_o   = qual_on ? own_dat   : '0;
    wb_dat64_o = qual_on ? own_dat64 : '0;
    m_ack_o    = bus_on ? (gnt_q & {N{wb_ack_i}}) : '0;
    m_rty_o    = bus_on ? (gnt_q & {N{wb_rty_i}}) : '0;
    m_err_o    = (bus_on ? (gnt_q & {N{wb_err_i}}) : '0) | (tmo_hit ? gnt_q : '0);
  end

  assign m_dat_o   = wb_dat_i;
  assign m_dat64_o = wb_dat64_i;
  assign gnt_o     = gnt_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: arbitration order, burst hold, steering, reset and abort behaviour.
// Inputs change and outputs are checked on the falling edge.
module tb_wb_arb;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   m_cyc, m_stb, m_we, m_cab;
  logic [4*N-1:0] m_sel;
  logic [32*N-1:0] m_adr, m_dat, m_dat64;
  logic [31:0]    m_dat_o, m_dat64_o;
  logic [N-1:0]   m_ack_o, m_err_o, m_rty_o;
  logic           wb_cyc_o, wb_stb_o, wb_we_o, wb_cab_o;
  logic [3:0]     wb_sel_o;
  logic [31:0]    wb_adr_o, wb_dat_o, wb_dat64_o;
  logic [31:0]    wb_dat_i, wb_dat64_i;
  logic           wb_ack_i, wb_err_i, wb_rty_i;
  logic [N-1:0]   gnt_o;
  logic [1:0]     arb_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arb #(.N(N), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_cab_i(m_cab),
    .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat64_i(m_dat64),
    .m_dat_o(m_dat_o), .m_dat64_o(m_dat64_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_cab_o(wb_cab_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat64_o(wb_dat64_o),
    .wb_dat_i(wb_dat_i), .wb_dat64_i(wb_dat64_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .gnt_o(gnt_o), .arb_state(arb_state)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c;
    int bad;
    logic [N-1:0] exp_g;
    int order [6] = '{0, 1, 2, 3, 4, 0};

    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cab = '0;
    m_sel = '0; m_adr = '0; m_dat = '0; m_dat64 = '0;
    wb_dat_i = 32'hCAFE_0001; wb_dat64_i = 32'hCAFE_0002;
    wb_ack_i = 1'b1; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state, with a stray ack on the bus
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_state", 64'(arb_state), 64'(0));
    chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("rst_stb", 64'(wb_stb_o), 64'(0));
    chk("rst_adr", 64'(wb_adr_o), 64'(0));
    chk("rst_ack", 64'(m_ack_o), 64'(0));
    chk("dat_passthru", 64'(m_dat_o), 64'(32'hCAFE_0001));
    chk("dat64_passthru", 64'(m_dat64_o), 64'(32'hCAFE_0002));
    wb_ack_i = 1'b0;
    rst = 1'b0;

    // Requesters 0 and 3 together: 0 wins, holds through a 4-beat cab burst
    m_cyc = 5'b01001; m_stb = 5'b01001; m_cab = 5'b00001;
    #1;
    chk("t1_idle_cyc", 64'(wb_cyc_o), 64'(0));
    tick();
    chk("t1_gnt0", 64'(gnt_o), 64'(5'b00001));
    chk("t1_cyc", 64'(wb_cyc_o), 64'(1));
    chk("t1_cab", 64'(wb_cab_o), 64'(1));
    wb_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("t1_burst_ack", 64'(m_ack_o), 64'(5'b00001));
      chk("t1_burst_gnt", 64'(gnt_o), 64'(5'b00001));
      tick();
    end
    wb_ack_i = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cab[0] = 1'b0;
    #1;
    chk("t1_release_cyc", 64'(wb_cyc_o), 64'(0));
    tick();
    chk("t1_idle_gnt", 64'(gnt_o), 64'(0));
    chk("t1_idle_cyc2", 64'(wb_cyc_o), 64'(0));
    tick();
    chk("t1_gnt3", 64'(gnt_o), 64'(5'b01000));
    chk("t1_cyc3", 64'(wb_cyc_o), 64'(1));
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    // Round-robin order across all five, one idle cycle between owners
    do_reset();
    m_cyc = 5'b11111; m_stb = 5'b11111;
    tick();
    for (int r = 0; r < 6; r++) begin
      exp_g = '0;
      exp_g[order[r]] = 1'b1;
      chk("t2_gnt", 64'(gnt_o), 64'(exp_g));
      chk("t2_cyc_on", 64'(wb_cyc_o), 64'(1));
      wb_ack_i = 1'b1;
      #1;
      chk("t2_ack", 64'(m_ack_o), 64'(exp_g));
      tick();
      wb_ack_i = 1'b0;
      m_cyc[order[r]] = 1'b0;
      tick();
      chk("t2_gap_cyc", 64'(wb_cyc_o), 64'(0));
      chk("t2_gap_gnt", 64'(gnt_o), 64'(0));
      m_cyc[order[r]] = 1'b1;
      tick();
    end
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    // Owner 2 write: qualifiers steered from its slice, ack only on bit 2
    m_adr = {5{32'hDEAD_BEEF}};
    m_sel = {5{4'h3}};
    m_adr[64 +: 32] = 32'h1000_0040;
    m_dat[64 +: 32] = 32'h1234_5678;
    m_sel[8 +: 4]   = 4'hF;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    tick();
    chk("t3_gnt", 64'(gnt_o), 64'(5'b00100));
    chk("t3_adr", 64'(wb_adr_o), 64'(32'h1000_0040));
    chk("t3_we", 64'(wb_we_o), 64'(1));
    chk("t3_sel", 64'(wb_sel_o), 64'(4'hF));
    chk("t3_dat", 64'(wb_dat_o), 64'(32'h1234_5678));
    chk("t3_no_ack", 64'(m_ack_o), 64'(0));
    wb_ack_i = 1'b1;
    #1;
    chk("t3_ack", 64'(m_ack_o), 64'(5'b00100));
    tick();
    wb_ack_i = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    tick();
    tick();

    // Reset during owner 1's burst, then 0 beats 1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cab[1] = 1'b1;
    tick();
    chk("t4_gnt1", 64'(gnt_o), 64'(5'b00010));
    tick();
    rst = 1'b1;
    #1;
    chk("t4_rst_cyc_now", 64'(wb_cyc_o), 64'(0));
    tick();
    chk("t4_rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("t4_rst_gnt", 64'(gnt_o), 64'(0));
    rst = 1'b0;
    m_cyc = 5'b00011; m_stb = 5'b00011;
    tick();
    chk("t4_gnt0", 64'(gnt_o), 64'(5'b00001));
    m_cyc = '0; m_stb = '0; m_cab = '0;
    tick();
    tick();

    // Owner 4 waits with no response
    m_cyc[4] = 1'b1; m_stb[4] = 1'b1;
    tick();
    chk("t5_gnt4", 64'(gnt_o), 64'(5'b10000));
`ifdef WB_ARB_TIMEOUT_EN
    c = 0;
    while (!m_err_o[4] && c < 400) begin
      tick();
      c++;
    end
    chk("t5_tmo_cycles", 64'(c), 64'(255));
    chk("t5_err_pulse", 64'(m_err_o), 64'(5'b10000));
    tick();
    chk("t5_err_done", 64'(m_err_o), 64'(0));
    chk("t5_abort_state", 64'(arb_state), 64'(2));
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) bad++;
      tick();
    end
    chk("t5_abort_cyc", 64'(bad), 64'(0));
    m_cyc = '0; m_stb = '0;
    tick();
    chk("t5_idle", 64'(arb_state), 64'(0));
`else
    bad = 0;
    for (c = 0; c < 1000; c++) begin
      if (m_err_o !== '0 || wb_stb_o !== 1'b1 || gnt_o !== 5'b10000) bad++;
      tick();
    end
    chk("t5_no_timeout", 64'(bad), 64'(0));
    m_cyc = '0; m_stb = '0;
    tick();
    chk("t5_idle", 64'(arb_state), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
